// File: rtl/ped_display_pkg.sv
// Shared glyphs, bitmaps and helpers for the pedestrian display driver.
package ped_display_pkg;

    // Seven-segment glyphs, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // 8x8 bitmaps, element [n] is matrix row n (row 7 listed first).
    localparam logic [7:0][7:0] STAND = {8'h24, 8'h24, 8'h24, 8'h18,
                                         8'h5A, 8'h3C, 8'h18, 8'h18};
    localparam logic [7:0][7:0] WALK0 = {8'h81, 8'h42, 8'h24, 8'h18,
                                         8'h5A, 8'h3C, 8'h18, 8'h18};
    localparam logic [7:0][7:0] WALK1 = {8'h08, 8'h48, 8'h28, 8'h18,
                                         8'h3A, 8'h1C, 8'h18, 8'h18};

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

    function automatic logic hurry(input logic [3:0] second);
        return (second >= 4'd1) && (second <= 4'd3);
    endfunction

endpackage

// File: rtl/ped_scan_timer.sv
// Row/digit scan timebase: divides clk by SCAN_DIV and steps row_idx 0..7,
// strobing frame_wrap_o on the cycle row_idx wraps 7->0.
module ped_scan_timer #(
    parameter int SCAN_DIV = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] row_idx_o,
    output logic       frame_wrap_o
);
    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [SCAN_W-1:0] scan_cnt_q;
    logic [2:0]        row_idx_q;
    logic              scan_wrap;

    assign scan_wrap    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign frame_wrap_o = scan_wrap && (row_idx_q == 3'd7);
    assign row_idx_o    = row_idx_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            row_idx_q  <= '0;
        end else if (scan_wrap) begin
            scan_cnt_q <= '0;
            row_idx_q  <= row_idx_q + 3'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
        end
    end

endmodule

// File: rtl/ped_display_driver.sv
// Pedestrian display driver: scanned 8x8 bicolour matrix plus 2-digit countdown.
// Optional macro PED_DISPLAY_BLINK_EN blinks the digits in hurry mode.
module ped_display_driver #(
    parameter int SCAN_DIV  = 500,
    parameter int FRAME_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] second,
    input  logic       pattern,
    input  logic       pause,
    output logic [7:0] row,
    output logic [7:0] col_r,
    output logic [7:0] col_g,
    output logic [6:0] seg,
    output logic [1:0] dig_sel
);
    import ped_display_pkg::*;

    localparam int FRM_W = $clog2(FRAME_DIV);
    localparam logic [FRM_W-1:0] LAST_NORMAL = FRM_W'(FRAME_DIV - 1);
    localparam logic [FRM_W-1:0] LAST_HURRY  = FRM_W'(FRAME_DIV / 2 - 1);

    logic [2:0]       row_idx;
    logic             frame_wrap;

    logic [3:0]       second_q, second_d;
    logic             pattern_q, pattern_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             frame_q, frame_d;
    logic [FRM_W-1:0] frm_last;
    logic             tens_slot;

    logic [7:0]       row_q, row_d;
    logic [7:0]       col_r_q, col_r_d;
    logic [7:0]       col_g_q, col_g_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       dig_sel_q, dig_sel_d;

    ped_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_idx_o   (row_idx),
        .frame_wrap_o(frame_wrap)
    );

    assign tens_slot = row_idx[0];
    assign frm_last  = hurry(second_q) ? LAST_HURRY : LAST_NORMAL;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        second_d  = second_q;
        pattern_d = pattern_q;
        frm_cnt_d = frm_cnt_q;
        frame_d   = frame_q;
        if (frame_wrap) begin
            second_d  = second;
            pattern_d = pattern;
        end

        // '>=' lets a count left above the shorter hurry period wrap at once.
        if (!pattern_q) begin
            frm_cnt_d = '0;
            frame_d   = 1'b0;
        end else if (!pause) begin
            if (frm_cnt_q >= frm_last) begin
                frm_cnt_d = '0;
                frame_d   = ~frame_q;
            end else begin
                frm_cnt_d = frm_cnt_q + FRM_W'(1);
            end
        end

        row_d   = 8'd1 << row_idx;
        col_r_d = pattern_q ? 8'h00 : STAND[row_idx];
        col_g_d = !pattern_q ? 8'h00 : (frame_q ? WALK1[row_idx] : WALK0[row_idx]);

        dig_sel_d = tens_slot ? 2'b10 : 2'b01;
        if (second_q == 4'd0) begin
            seg_d = SEG_BLANK;
        end else if (second_q > 4'd10) begin
            seg_d = SEG_DASH;
        end else if (tens_slot) begin
            seg_d = (second_q == 4'd10) ? SEG_1 : SEG_BLANK;
        end else begin
            seg_d = (second_q == 4'd10) ? SEG_0 : seg_decode(second_q);
        end
`ifdef PED_DISPLAY_BLINK_EN
        if (pattern_q && hurry(second_q) && frame_q) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            second_q  <= '0;
            pattern_q <= 1'b0;
            frm_cnt_q <= '0;
            frame_q   <= 1'b0;
            row_q     <= '0;
            col_r_q   <= '0;
            col_g_q   <= '0;
            seg_q     <= '0;
            dig_sel_q <= '0;
        end else begin
            second_q  <= second_d;
            pattern_q <= pattern_d;
            frm_cnt_q <= frm_cnt_d;
            frame_q   <= frame_d;
            row_q     <= row_d;
            col_r_q   <= col_r_d;
            col_g_q   <= col_g_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign row     = row_q;
    assign col_r   = col_r_q;
    assign col_g   = col_g_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_ped_display_driver.sv
// Self-checking bench for ped_display_driver (SCAN_DIV=2, FRAME_DIV=8) against
// a cycle-count reference model; honours PED_DISPLAY_BLINK_EN when defined.
module tb_ped_display_driver;
    localparam int SD = 2;
    localparam int FD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] second = 4'd0;
    logic       pattern = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] row, col_r, col_g;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state: cycles since reset, latched inputs, animation.
    int   m_cyc = 0;
    int   m_sec = 0;
    bit   m_pat = 1'b0;
    int   m_fcnt = 0;
    bit   m_frame = 1'b0;
    logic [7:0] exp_row, exp_col_r, exp_col_g;
    logic [6:0] exp_seg;
    logic [1:0] exp_dig;

    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [7:0] stand_bm [8] = '{8'h18, 8'h18, 8'h3C, 8'h5A, 8'h18, 8'h24, 8'h24, 8'h24};
    logic [7:0] walk_bm [2][8] = '{'{8'h18, 8'h18, 8'h3C, 8'h5A, 8'h18, 8'h24, 8'h42, 8'h81},
                                   '{8'h18, 8'h18, 8'h1C, 8'h3A, 8'h18, 8'h28, 8'h48, 8'h08}};

    ped_display_driver #(.SCAN_DIV(SD), .FRAME_DIV(FD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .second (second),
        .pattern(pattern),
        .pause  (pause),
        .row    (row),
        .col_r  (col_r),
        .col_g  (col_g),
        .seg    (seg),
        .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(input int sec, input bit tens);
        if (sec == 0) return 7'h00;
        if (sec > 10) return 7'h40;
        if (tens) return (sec / 10 != 0) ? glyph[1] : 7'h00;
        return glyph[sec % 10];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%02h expected=%02h", tag, m_cyc, obs, expv);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int r;
        int last;
        @(posedge clk);
        if (!rst_n) begin
            m_cyc = 0; m_sec = 0; m_pat = 1'b0; m_fcnt = 0; m_frame = 1'b0;
            exp_row = '0; exp_col_r = '0; exp_col_g = '0; exp_seg = '0; exp_dig = '0;
        end else begin
            r = (m_cyc / SD) % 8;
            exp_row   = 8'(1 << r);
            exp_col_r = m_pat ? 8'h00 : stand_bm[r];
            exp_col_g = m_pat ? walk_bm[m_frame][r] : 8'h00;
            exp_dig   = (r % 2 == 1) ? 2'b10 : 2'b01;
            exp_seg   = model_seg(m_sec, r % 2 == 1);
`ifdef PED_DISPLAY_BLINK_EN
            if (m_pat && m_sec >= 1 && m_sec <= 3 && m_frame) exp_seg = 7'h00;
`endif
            last = (m_sec >= 1 && m_sec <= 3) ? FD / 2 : FD;
            if (!m_pat) begin
                m_fcnt = 0; m_frame = 1'b0;
            end else if (!pause) begin
                if (m_fcnt + 1 >= last) begin
                    m_fcnt = 0; m_frame = ~m_frame;
                end else begin
                    m_fcnt++;
                end
            end
            if ((m_cyc + 1) % (8 * SD) == 0) begin
                m_sec = int'(second); m_pat = pattern;
            end
            m_cyc++;
        end
        #1;
        check("row", row, exp_row);
        check("col_r", col_r, exp_col_r);
        check("col_g", col_g, exp_col_g);
        check("seg", {1'b0, seg}, {1'b0, exp_seg});
        check("dig_sel", {6'b0, dig_sel}, {6'b0, exp_dig});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        run(3);                                // held in reset
        rst_n = 1'b1;
        run(36);                               // idle stand, blank digits
        second = 4'd10; pattern = 1'b1;        // applied mid-frame
        run(40);
        second = 4'd5;
        run(48);
        second = 4'd3;
        run(40);
        second = 4'd7;
        run(21);
        pause = 1'b1;
        run(20);
        pause = 1'b0;
        run(24);
        for (int i = 0; i < 40 && !(m_pat && m_frame); i++) step();
        rst_n = 1'b0;                          // one-cycle reset mid-walk
        run(1);
        rst_n = 1'b1;
        run(40);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) second = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) pattern = ~pattern;
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
